// File: rtl/serial_pkg.sv
// Shared definitions for the serial transmit/capture pair.
package serial_pkg;

  localparam int unsigned DEF_DATA_W       = 8;
  localparam int unsigned DEF_CLKS_PER_BIT = 4;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } state_t;

endpackage

// File: rtl/serial_frame_tx_bit_timer.sv
// Enable-gated modulo-CLKS_PER_BIT counter marking the last cycles of a serial bit.
module bit_timer
  import serial_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = DEF_CLKS_PER_BIT
) (
  input  logic CLK,
  input  logic RST_n,
  input  logic ena,
  input  logic clr_n,
  output logic bit_end,
  output logic bit_pre_end
);

  localparam int unsigned CNT_W = $clog2(CLKS_PER_BIT);

  logic [CNT_W-1:0] cnt;

  // Count within a bit; wraps at the bit boundary, held at 0 while cleared.
  always_ff @(negedge CLK) begin
    if (!RST_n) begin
      cnt <= '0;
    end else if (ena) begin
      if (!clr_n || bit_end) cnt <= '0;
      else                   cnt <= cnt + CNT_W'(1);
    end
  end

  assign bit_end     = (cnt == CNT_W'(CLKS_PER_BIT - 1));
  assign bit_pre_end = (cnt == CNT_W'(CLKS_PER_BIT - 2));

endmodule

// File: rtl/serial_frame_tx.sv
// Parallel-in, serial-out frame transmitter: start, data LSB first, optional even parity, stop.
module serial_frame_tx
  import serial_pkg::*;
#(
  parameter int unsigned DATA_W       = DEF_DATA_W,
  parameter int unsigned CLKS_PER_BIT = DEF_CLKS_PER_BIT,
  parameter bit          PARITY_EN    = 1'b1
) (
  input  logic              CLK,
  input  logic              RST_n,
  input  logic              ena,
  input  logic [DATA_W-1:0] din,
  input  logic              load,
  output logic              ready,
  output logic              txd,
  output logic              busy,
  output logic              done
);

  localparam int unsigned BCNT_W = $clog2(DATA_W + 1);

  state_t              state;
  logic [DATA_W-1:0]   shreg;
  logic [DATA_W-1:0]   shreg_nxt;
  logic                parity;
  logic [BCNT_W-1:0]   bit_cnt;
  logic                bit_end;
  logic                bit_pre_end;
  logic                tmr_clr_n;

  // Timer runs only while a frame is in flight, so each frame starts on a fresh bit.
  assign tmr_clr_n = (state != IDLE);
  assign shreg_nxt = shreg >> 1;

  bit_timer #(
    .CLKS_PER_BIT (CLKS_PER_BIT)
  ) u_bit_timer (
    .CLK         (CLK),
    .RST_n       (RST_n),
    .ena         (ena),
    .clr_n       (tmr_clr_n),
    .bit_end     (bit_end),
    .bit_pre_end (bit_pre_end)
  );

  // Frame FSM; txd/busy/ready/done are registered alongside the state.
  always_ff @(negedge CLK) begin
    if (!RST_n) begin
      state   <= IDLE;
      txd     <= 1'b1;
      busy    <= 1'b0;
      ready   <= 1'b1;
      done    <= 1'b0;
      shreg   <= '0;
      parity  <= 1'b0;
      bit_cnt <= '0;
    end else if (ena) begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (load) begin
            shreg  <= din;
            parity <= ^din;
            state  <= START;
            txd    <= 1'b0;
            busy   <= 1'b1;
            ready  <= 1'b0;
          end
        end
        START: begin
          if (bit_end) begin
            state   <= DATA;
            bit_cnt <= '0;
            txd     <= shreg[0];
          end
        end
        DATA: begin
          if (bit_end) begin
            shreg   <= shreg_nxt;
            bit_cnt <= bit_cnt + BCNT_W'(1);
            if (bit_cnt == BCNT_W'(DATA_W - 1)) begin
              if (PARITY_EN) begin
                state <= PARITY;
                txd   <= parity;
              end else begin
                state <= STOP;
                txd   <= 1'b1;
              end
            end else begin
              txd <= shreg_nxt[0];
            end
          end
        end
        PARITY: begin
          if (bit_end) begin
            state <= STOP;
            txd   <= 1'b1;
          end
        end
        STOP: begin
          // Registered pulse lands in the final cycle of the stop bit.
          if (bit_pre_end) done <= 1'b1;
          if (bit_end) begin
            state <= IDLE;
            busy  <= 1'b0;
            ready <= 1'b1;
            txd   <= 1'b1;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
          ready <= 1'b1;
          txd   <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_frame_tx.sv
// Scoreboard bench for serial_frame_tx: parity and no-parity instances share stimulus.
module tb_serial_frame_tx;

  localparam int unsigned DW  = 8;
  localparam int unsigned CPB = 4;

  logic          CLK;
  logic          RST_n;
  logic          ena;
  logic [DW-1:0] din;
  logic          load;
  logic          load_np;
  logic          ready, txd, busy, done;
  logic          ready_np, txd_np, busy_np, done_np;

  int checks = 0;
  int fails  = 0;

  typedef struct {
    logic [15:0] data;
    logic        par;
    bit          pen;
    int          len;
    int          wall;
    bit          abort;
  } exp_t;

  exp_t q0[$];
  exp_t q1[$];

  serial_frame_tx #(.DATA_W(DW), .CLKS_PER_BIT(CPB), .PARITY_EN(1'b1)) dut (
    .CLK(CLK), .RST_n(RST_n), .ena(ena), .din(din), .load(load),
    .ready(ready), .txd(txd), .busy(busy), .done(done)
  );

  serial_frame_tx #(.DATA_W(DW), .CLKS_PER_BIT(CPB), .PARITY_EN(1'b0)) dut_np (
    .CLK(CLK), .RST_n(RST_n), .ena(ena), .din(din), .load(load_np),
    .ready(ready_np), .txd(txd_np), .busy(busy_np), .done(done_np)
  );

  initial CLK = 1'b1;
  always #5 CLK = ~CLK;

  // Remember whether the most recent active edge was enabled.
  bit en_edge = 1'b0;
  always @(negedge CLK) en_edge = ena;

  task automatic check(input string name, input int act, input int exp_v);
    checks++;
    if (act != exp_v) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp_v, $time);
    end
  endtask

  // Reference line level at enabled cycle k of a frame.
  function automatic logic exp_bit(input logic [15:0] d, input logic p, input bit pen, input int k);
    int slot;
    slot = k / int'(CPB);
    if (slot == 0) return 1'b0;
    if (slot <= int'(DW)) return d[slot-1];
    if (pen && slot == int'(DW) + 1) return p;
    return 1'b1;
  endfunction

  task automatic push(input int inst, input logic [7:0] d, input logic p, input bit pen,
                      input int len, input int wall, input bit abort);
    exp_t e;
    e.data = {8'h00, d}; e.par = p; e.pen = pen; e.len = len; e.wall = wall; e.abort = abort;
    if (inst == 0) q0.push_back(e);
    else           q1.push_back(e);
  endtask

  // Monitor state, one slot per instance.
  logic mb[2], mt[2], md[2], mr[2];
  bit   in_frame[2];
  int   flen[2], fwall[2], dcnt[2], dpos[2];
  logic seq[2][128];

  task automatic close_frame(input int i);
    exp_t e;
    int   bad;
    int   first;
    if ((i == 0 && q0.size() == 0) || (i == 1 && q1.size() == 0)) begin
      checks++;
      fails++;
      $display("FAIL unexpected_frame inst%0d: got frame of %0d cycles, expected none", i, flen[i]);
      return;
    end
    if (i == 0) e = q0.pop_front();
    else        e = q1.pop_front();
    check($sformatf("frame_len inst%0d data=%02h", i, e.data[7:0]), flen[i], e.len);
    check($sformatf("frame_wall inst%0d data=%02h", i, e.data[7:0]), fwall[i], e.wall);
    bad = 0;
    first = -1;
    for (int k = 0; k < flen[i] && k < 128; k++) begin
      if (seq[i][k] !== exp_bit(e.data, e.par, e.pen, k)) begin
        bad++;
        if (first < 0) first = k;
      end
    end
    check($sformatf("frame_bit_errors inst%0d data=%02h first_bad=%0d", i, e.data[7:0], first), bad, 0);
    check($sformatf("done_count inst%0d data=%02h", i, e.data[7:0]), dcnt[i], e.abort ? 0 : 1);
    if (!e.abort) check($sformatf("done_pos inst%0d data=%02h", i, e.data[7:0]), dpos[i], e.len);
    check($sformatf("ready_after inst%0d data=%02h", i, e.data[7:0]), int'(mr[i] === 1'b1), 1);
  endtask

  // Capture each frame per enabled cycle and compare when busy drops.
  always @(posedge CLK) begin
    mb[0] = busy;  mb[1] = busy_np;
    mt[0] = txd;   mt[1] = txd_np;
    md[0] = done;  md[1] = done_np;
    mr[0] = ready; mr[1] = ready_np;
    for (int i = 0; i < 2; i++) begin
      if (mb[i] === 1'b1) begin
        if (!in_frame[i]) begin
          in_frame[i] = 1'b1;
          flen[i] = 0; fwall[i] = 0; dcnt[i] = 0; dpos[i] = 0;
        end
        fwall[i]++;
        if (en_edge) begin
          if (flen[i] < 128) seq[i][flen[i]] = mt[i];
          flen[i]++;
          if (md[i] === 1'b1) begin
            dcnt[i]++;
            dpos[i] = flen[i];
          end
        end
      end else if (in_frame[i]) begin
        in_frame[i] = 1'b0;
        close_frame(i);
      end
    end
  end

  task automatic send(input logic [7:0] d, input bit to_np);
    @(posedge CLK);
    din = d; load = 1'b1; load_np = to_np;
    @(posedge CLK);
    load = 1'b0; load_np = 1'b0;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while ((busy !== 1'b0 || busy_np !== 1'b0) && n < 200) begin
      @(posedge CLK);
      n++;
    end
    if (n >= 200) begin
      checks++;
      fails++;
      $display("FAIL idle_timeout: got busy=%0b after %0d cycles, expected 0", busy, n);
    end
    repeat (2) @(posedge CLK);
  endtask

  initial begin
    RST_n = 1'b0; ena = 1'b1; din = 8'hFF; load = 1'b1; load_np = 1'b1;

    // Reset dominates a pending load.
    repeat (3) begin
      @(posedge CLK);
      check("rst_txd", int'(txd), 1);
      check("rst_ready", int'(ready), 1);
      check("rst_busy", int'(busy), 0);
      check("rst_done", int'(done), 0);
    end
    RST_n = 1'b1; load = 1'b0; load_np = 1'b0;
    repeat (4) @(posedge CLK);
    check("post_rst_idle_busy", int'(busy), 0);
    check("post_rst_idle_txd", int'(txd), 1);

    // Single frame with defaults.
    push(0, 8'hA5, 1'b0, 1'b1, 44, 44, 1'b0);
    send(8'hA5, 1'b0);
    wait_idle();

    // Odd popcount: parity 1; the no-parity instance sends 40 cycles.
    push(0, 8'h07, 1'b1, 1'b1, 44, 44, 1'b0);
    push(1, 8'h07, 1'b1, 1'b0, 40, 40, 1'b0);
    send(8'h07, 1'b1);
    wait_idle();

    // Load while busy is dropped.
    push(0, 8'hA5, 1'b0, 1'b1, 44, 44, 1'b0);
    send(8'hA5, 1'b0);
    repeat (9) @(posedge CLK);
    din = 8'h3C; load = 1'b1;
    @(posedge CLK);
    load = 1'b0;
    wait_idle();
    check("no_queued_frame_busy", int'(busy), 0);

    // Five frozen edges inside data bit 3.
    push(0, 8'hA5, 1'b0, 1'b1, 44, 49, 1'b0);
    send(8'hA5, 1'b0);
    repeat (17) @(posedge CLK);
    ena = 1'b0;
    repeat (3) @(posedge CLK);
    check("ena_hold_txd_bit3", int'(txd), 0);
    repeat (2) @(posedge CLK);
    ena = 1'b1;
    wait_idle();

    // Reset during data bit 5 aborts after 26 enabled cycles.
    push(0, 8'hA5, 1'b0, 1'b1, 26, 26, 1'b1);
    send(8'hA5, 1'b0);
    repeat (25) @(posedge CLK);
    RST_n = 1'b0;
    @(posedge CLK);
    check("abort_txd", int'(txd), 1);
    check("abort_busy", int'(busy), 0);
    check("abort_ready", int'(ready), 1);
    RST_n = 1'b1;
    wait_idle();

    // Clean frame after the abort.
    push(0, 8'h81, 1'b0, 1'b1, 44, 44, 1'b0);
    send(8'h81, 1'b0);
    wait_idle();

    check("q0_drained", q0.size(), 0);
    check("q1_drained", q1.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got no completion, expected finish");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/serial_frame_tx.md
Name: serial_frame_tx

Overview:
- Parallel-in, serial-out frame transmitter that drives a single-wire line.
- Counterpart of the team's D-flip-flop based serial capture chain: this block shifts bytes out, and the capture chain samples them in.
- Frame format: start bit (0), DATA_W data bits LSB first, optional even-parity bit, one stop bit (1).
- Sits between a byte producer (load/ready handshake) and the board-level txd pin.

Parameters:
- DATA_W, 8, data bits per frame (1..16).
- CLKS_PER_BIT, 4, CLK cycles per serial bit (>=2).
- PARITY_EN, 1, 1 = insert even-parity bit after the data bits; 0 = no parity bit.

Ports:
- CLK  input  1  clock; all state updates on the falling edge, matching the team's storage elements.
- RST_n  input  1  reset, synchronous, active-low.
- ena  input  1  clock enable; 0 freezes all state and outputs, including the bit timer.
- din  input  DATA_W  byte to send; sampled only on an accepted load.
- load  input  1  request to send din.
- ready  output  1  1 when a load will be accepted this cycle.
- txd  output  1  serial line; idles at 1.
- busy  output  1  1 while a frame is in progress.
- done  output  1  one-cycle pulse in the last cycle of the stop bit.

Behaviour:
- Reset, applied on a CLK falling edge while RST_n=0 (ena ignored): state=IDLE, txd=1, busy=0, ready=1, done=0, shift register=0, bit timer=0, bit count=0.
- Reset asserted mid-frame aborts the frame immediately; txd returns to 1 on that edge. No partial stop bit is required.
- All non-reset updates occur only when ena=1. With ena=0, txd holds its current level and timing stretches accordingly.
- State machine:
  - IDLE: txd=1, ready=1. If load=1: capture din into the shift register, compute parity = XOR of din, clear the timer, go to START. An accepted load means load=1 and ready=1 on the same edge.
  - START: txd=0 for CLKS_PER_BIT cycles, then go to DATA with bit count 0.
  - DATA: txd=shreg[0]. Each bit lasts CLKS_PER_BIT cycles. At the end of each bit, shift right and increment the bit count. After bit DATA_W-1, go to PARITY if PARITY_EN=1, else STOP.
  - PARITY: txd=parity for CLKS_PER_BIT cycles, then go to STOP.
  - STOP: txd=1 for CLKS_PER_BIT cycles. done=1 during the final cycle of this bit. Then go to IDLE.
- ready=1 only in IDLE. busy = (state != IDLE). txd is registered, so it changes on the same edge as the state.
- Latency: the first edge after an accepted load drives txd=0.
- Frame length is (2 + DATA_W + PARITY_EN) * CLKS_PER_BIT enabled cycles.
- A load while busy is ignored. It is not queued, and din changes mid-frame have no effect.
- Back-to-back transfers: load may be asserted in the cycle after done. The minimum gap between frames is one IDLE cycle at txd=1.
- Bit timer: counts 0..CLKS_PER_BIT-1 and wraps to 0 at the end of every bit, with $clog2(CLKS_PER_BIT) bits. The bit count width is $clog2(DATA_W+1).
- Simultaneous reset and load: reset wins.

Decomposition:
- Shared package (serial_pkg):
  - state encoding localparams IDLE=3'd0, START=3'd1, DATA=3'd2, PARITY=3'd3, STOP=3'd4;
  - the default constants for DATA_W and CLKS_PER_BIT, shared with the receive side.
- One natural sub-module, bit_timer:
  - enable-gated modulo-CLKS_PER_BIT counter with synchronous active-low clear;
  - outputs bit_end (high in the last cycle of each bit).
- The FSM, shift register and parity logic stay in the top module.

Test Plan:
- Reset check: hold RST_n=0 for 3 edges with load=1 and din=8'hFF -> txd=1, ready=1, busy=0, done=0 throughout. No frame starts after release unless load is still high.
- Single frame, defaults: load din=8'hA5 for one cycle -> txd over 44 cycles, in 4-cycle bits: 0 | 1,0,1,0,0,1,0,1 | parity 0 | 1. done pulses once at cycle 44. ready returns to 1 at cycle 45.
- Parity odd-count data: din=8'h07 -> data bits 1,1,1,0,0,0,0,0, parity bit 1. With PARITY_EN=0, the frame is 40 cycles with no parity bit.
- Load while busy: second load with din=8'h3C at cycle 10 of an 8'hA5 frame -> ignored; the serial output stays 8'hA5 and busy does not extend.
- ena gating: drop ena to 0 for 5 cycles in the middle of data bit 3 -> txd holds the bit-3 value. The frame completes exactly 5 cycles later than nominal with an identical bit sequence.
- Mid-frame reset: assert RST_n=0 during data bit 5 -> txd=1 and busy=0 on that edge. A load of 8'h81 after release yields a clean frame starting with a fresh 4-cycle start bit.
